// File: rtl/risc_wbuf.sv
// Posted-write buffer between the risc core bus and memory: single-cycle write capture,
// coalescing, req/ack drain of the head entry, and combinational store-to-load forwarding.
module risc_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          rw,
  inout  wire  [DW-1:0] data,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wreq,
  input  logic          mem_wack,
  output logic          empty,
  output logic          full,
  output logic          overflow
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_head, r_tail;
  logic [PW:0]              r_count;
  logic                     r_wreq, r_ovf;

  logic [DEPTH-1:0] w_hit;
  logic [DW-1:0]    w_fwd;
  logic [PW-1:0]    w_idx;
  logic             w_co;
  logic [PW-1:0]    w_co_idx;
  logic             w_retire, w_head_ow, w_alloc, w_drop;
  logic [PW:0]      w_cnt_nxt;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_hit
      assign w_hit[g] = r_vld[g] && (r_addr[g] == address);
    end
  endgenerate

  // Walk from head toward tail so the last hit seen is the newest write.
  always_comb begin
    w_fwd = mem_rdata;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (w_hit[w_idx]) w_fwd = r_data[w_idx];
    end
  end

  // Coalescing keeps at most one non-head copy of any address.
  always_comb begin
    w_co     = 1'b0;
    w_co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_hit[i] && (PW'(i) != r_head)) begin
        w_co     = 1'b1;
        w_co_idx = PW'(i);
      end
    end
  end

  assign w_retire  = r_wreq && mem_wack;
  assign w_head_ow = !rw && !w_co && w_hit[r_head] && !r_wreq && (r_count == (PW+1)'(1));
  assign w_alloc   = !rw && !w_co && !w_head_ow && (!full || w_retire);
  assign w_drop    = !rw && !w_co && !w_head_ow && !w_alloc;
  assign w_cnt_nxt = r_count + {{PW{1'b0}}, w_alloc} - {{PW{1'b0}}, w_retire};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_wreq  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_retire) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_co)      r_data[w_co_idx] <= data;
      if (w_head_ow) r_data[r_head]   <= data;
      // Placed after the retire so a slot freed at this edge is refilled, not cleared.
      if (w_alloc) begin
        r_addr[r_tail] <= address;
        r_data[r_tail] <= data;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_drop) r_ovf <= 1'b1;
      r_count <= w_cnt_nxt;
      r_wreq  <= (w_cnt_nxt != '0);
    end
  end

  assign data      = rw ? w_fwd : {DW{1'bz}};
  assign mem_raddr = address;
  assign mem_waddr = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign mem_wreq  = r_wreq;
  assign empty     = (r_count == '0);
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_risc_wbuf.sv
// Scoreboard bench for risc_wbuf: a queue model of the buffer predicts flags, forwarded
// reads and the order of drained writes, which are popped as the memory acks them.
module tb_risc_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        rw;
  wire  [15:0] data;
  logic        tb_oe;
  logic [15:0] tb_wd;
  logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_wreq, mem_wack, empty, full, overflow;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf;
  int          checks, errors, retires;
  logic [15:0] z16;

  assign data      = tb_oe ? tb_wd : 16'hzzzz;
  assign mem_rdata = mem_raddr ^ 16'hC3C3;

  always #5 clk = ~clk;

  risc_wbuf #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset), .address(address), .rw(rw), .data(data),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wreq(mem_wreq), .mem_wack(mem_wack),
    .empty(empty), .full(full), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [15:0] r;
    r = a ^ 16'hC3C3;
    foreach (q[i]) if (q[i].a == a) r = q[i].d;
    return r;
  endfunction

  // Entered and left at posedge+1; outputs are checked mid-cycle, then the model steps.
  task automatic cyc(input logic r, input logic [15:0] a, input logic [15:0] d, input logic ack);
    ent_t e;
    int   hit;
    logic ret;
    rw = r; address = a; tb_wd = d; tb_oe = !r; mem_wack = ack;
    #3;
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("mem_wreq", 32'(mem_wreq), 32'(q.size() != 0));
    check("mem_raddr", 32'(mem_raddr), 32'(a));
    if (q.size() != 0) begin
      check("mem_waddr", 32'(mem_waddr), 32'(q[0].a));
      check("mem_wdata", 32'(mem_wdata), 32'(q[0].d));
    end
    if (r) check("read", 32'(data), 32'(m_read(a)));
    ret = ack && (q.size() != 0);
    if (!r) begin
      hit = -1;
      for (int i = 1; i < q.size(); i++) if (q[i].a == a) hit = i;
      if (hit >= 0) q[hit].d = d;
      else if (q.size() < DEPTH || ret) begin
        e.a = a; e.d = d;
        q.push_back(e);
      end else m_ovf = 1'b1;
    end
    if (ret) begin
      void'(q.pop_front());
      retires++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int r0;
    checks = 0; errors = 0; retires = 0; m_ovf = 1'b0; z16 = 16'hzzzz;
    reset = 1'b0; rw = 1'b1; address = 16'h0; tb_oe = 1'b0; tb_wd = 16'h0; mem_wack = 1'b0;
    #2;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_wreq", 32'(mem_wreq), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // basic posting and forwarding
    cyc(0, 16'h0010, 16'hBEEF, 0);
    cyc(1, 16'h0010, 16'h0, 0);
    cyc(1, 16'h0010, 16'h0, 1);
    cyc(1, 16'h0010, 16'h0, 0);

    // coalescing, and no coalescing into the in-flight head
    cyc(0, 16'h0020, 16'h0001, 0);
    cyc(0, 16'h0030, 16'h0002, 0);
    cyc(0, 16'h0030, 16'h0003, 0);
    cyc(1, 16'h0030, 16'h0, 0);
    cyc(0, 16'h0020, 16'h0004, 0);
    cyc(1, 16'h0020, 16'h0, 0);
    repeat (4) cyc(1, 16'h0000, 16'h0, 1);

    // full, overflow, and reuse of the slot freed at the same edge
    for (int i = 0; i < 5; i++) cyc(0, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 0);
    cyc(1, 16'h0104, 16'h0, 0);
    cyc(0, 16'h0105, 16'h0055, 1);
    cyc(1, 16'h0105, 16'h0, 0);
    repeat (5) cyc(1, 16'h0000, 16'h0, 1);

    // asynchronous reset with entries queued and a request in flight
    for (int i = 0; i < 3; i++) cyc(0, 16'h0040 + 16'(i), 16'h0A00 + 16'(i), 0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_wreq", 32'(mem_wreq), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    q.delete(); m_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1, 16'h0010, 16'h0, 0);

    // wrap-around with ack tied high: one retire per cycle, in order
    r0 = retires;
    for (int i = 0; i < 10; i++) cyc(0, 16'h0200 + 16'(i * 3), 16'(i * 7 + 1), 1);
    cyc(1, 16'h0000, 16'h0, 1);
    cyc(1, 16'h0000, 16'h0, 0);
    check("drain_count", 32'(retires - r0), 32'd10);

    // bus direction
    rw = 1'b0; tb_oe = 1'b0; address = 16'h0300; mem_wack = 1'b0;
    #2 check("data_hiz", 32'(data), 32'(z16));
    rw = 1'b1;
    #1 check("data_driven", 32'(data), 32'(m_read(16'h0300)));
    @(posedge clk); #1;

    // mixed traffic over a small address set
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), 16'h0500 + 16'($urandom_range(0, 5)),
          16'($urandom), 1'($urandom_range(0, 1)));
    repeat (6) cyc(1, 16'h0500, 16'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
